gate_sequencer: RTL and testbench
=================================

Name: gate_sequencer

Overview:
- Circuit-program feeder that drives the gate-info side of the stabilizer emulation top.
- Holds a gate list written by the host. On run, it pulses start together with gate 0.
- Presents each next gate after every update_gate_info pulse from the emulator.
- After the last gate it waits for done_readout and reports completion.

Parameters:
num_qubit, 3, qubit count; legal qubit positions are 0..num_qubit-1
total_gate, 30, program depth (entries 0..total_gate-1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
prog_we  input  1  program write strobe; honoured only in IDLE
prog_addr  input  32  write address; writes with prog_addr>=total_gate ignored
prog_gate_type  input  2  0 H, 1 Phase, 2 CNOT, 3 Measurement
prog_qubit_pos  input  32  target (CNOT control)
prog_qubit_pos2  input  32  CNOT target; don't-care otherwise
num_gate  input  32  gates to run; sampled on run
run  input  1  start request; honoured only in IDLE
update_gate_info  input  1  one-cycle pulse from emulator: current gate consumed
done_readout  input  1  emulator final readout finished
start  output  1  one-cycle pulse, coincident with gate 0 on gate outputs
gate_type  output  2  current gate type (registered)
qubit_pos  output  32  current qubit_pos (registered)
qubit_pos2  output  32  current qubit_pos2 (registered)
gate_index  output  32  index of gate currently presented
busy  output  1  high from start through DONE
done  output  1  one-cycle pulse on completion
cfg_err  output  1  sticky: run rejected (num_gate==0 or >total_gate); cleared by next accepted run or reset

Behaviour:
- Reset (rst=0, async): state IDLE; start=0, done=0, busy=0, cfg_err=0, gate_type=0, qubit_pos=0, qubit_pos2=0, gate_index=0. Program memory is not reset.
- Memory: total_gate entries of {2b type, 32b pos, 32b pos2}. Write takes effect at the clock edge when prog_we=1 and state is IDLE.
- FSM states and transitions:
  - IDLE:
    - run=1 with 1<=num_gate<=total_gate: latch num_gate, load entry 0 into the output regs, gate_index=0, start=1 for that next cycle, busy=1, cfg_err=0. Next state RUN.
    - run=1 with illegal num_gate: cfg_err=1; stay IDLE.
    - run and prog_we in the same cycle: the write happens; run reads the pre-write entry 0.
  - RUN:
    - On update_gate_info=1 with gate_index+1<latched count: load entry gate_index+1, increment gate_index. New values visible the cycle after the pulse.
    - On update_gate_info=1 with the last gate: next state DRAIN. Outputs hold the last gate.
    - update_gate_info coincident with the start cycle is legal and advances normally.
  - DRAIN: on done_readout=1 go to DONE. A done_readout seen in RUN is ignored.
  - DONE: done=1 for one cycle, busy=0, next state IDLE. Gate outputs hold their last values.
- Ignored inputs:
  - run while not IDLE.
  - update_gate_info in IDLE, DRAIN or DONE.
  - prog_we while not IDLE.
- Latency: run to start, 1 cycle. update_gate_info to new gate, 1 cycle. done_readout to done, 1 cycle.
- Reset mid-run aborts to IDLE immediately. The program is retained and can be rerun.

Optional Feature:
GATE_CHECK_EN
- Defined: adds output gate_err (1 bit, sticky, reset 0, cleared by an accepted run).
  - Set when a loaded gate has qubit_pos>=num_qubit.
  - Or when a loaded CNOT has qubit_pos2>=num_qubit or qubit_pos2==qubit_pos.
  - The offending gate is still issued. gate_err rises in the same cycle the gate appears on the outputs.
- Undefined: no gate_err port and no checking logic.

Test Plan:
- Program 3 gates {H q0},{CNOT 0->1},{S q2}; num_gate=3; run -> next cycle start=1 with type 0 / pos 0, gate_index=0. Three spaced update_gate_info pulses -> type 2 / 0 / 1, then type 1 / pos 2, then DRAIN. done_readout -> done pulse 1 cycle later, busy=0.
- run with num_gate=0, then with num_gate=31 -> cfg_err=1, no start, stays IDLE. Valid run -> cfg_err=0.
- update_gate_info asserted on the start cycle and on every later cycle, num_gate=4 -> gate_index 0,1,2,3 on consecutive cycles, then DRAIN.
- prog_we and a second run during RUN -> memory unchanged, no second start. update_gate_info in IDLE -> outputs unchanged.
- rst=0 asserted mid-RUN at gate_index=2 -> all outputs 0 immediately. Rerun -> the same program replays from gate 0.
- GATE_CHECK_EN: program {CNOT 1->1} with num_qubit=3 -> gate_err=1 in the cycle the gate is presented, and stays set until the next accepted run.

Source files
------------

// File: rtl/gate_sequencer_if.sv
// Host/emulator-side signal bundle of gate_sequencer: program load, run control,
// and the gate-info handshake. GATE_CHECK_EN adds the gate_err flag.
interface gate_sequencer_if;
  // host program port and run control
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [1:0]  prog_gate_type;
  logic [31:0] prog_qubit_pos;
  logic [31:0] prog_qubit_pos2;
  logic [31:0] num_gate;
  logic        run;
  // emulator handshake
  logic        update_gate_info;
  logic        done_readout;
  // sequencer outputs
  logic        start;
  logic [1:0]  gate_type;
  logic [31:0] qubit_pos;
  logic [31:0] qubit_pos2;
  logic [31:0] gate_index;
  logic        busy;
  logic        done;
  logic        cfg_err;
`ifdef GATE_CHECK_EN
  logic        gate_err;
`endif

  modport master (
    output prog_we, prog_addr, prog_gate_type, prog_qubit_pos, prog_qubit_pos2,
    output num_gate, run, update_gate_info, done_readout,
    input  start, gate_type, qubit_pos, qubit_pos2, gate_index, busy, done, cfg_err
`ifdef GATE_CHECK_EN
    , input gate_err
`endif
  );

  modport slave (
    input  prog_we, prog_addr, prog_gate_type, prog_qubit_pos, prog_qubit_pos2,
    input  num_gate, run, update_gate_info, done_readout,
    output start, gate_type, qubit_pos, qubit_pos2, gate_index, busy, done, cfg_err
`ifdef GATE_CHECK_EN
    , output gate_err
`endif
  );
endinterface

// File: rtl/gate_sequencer.sv
// Gate-program feeder for the stabilizer emulator: stores a host-written gate list and
// steps through it on update_gate_info. Define GATE_CHECK_EN to add qubit-range checking.
module gate_sequencer #(
  parameter int num_qubit  = 3,
  parameter int total_gate = 30
) (
  input  logic             clk,
  input  logic             rst,
  gate_sequencer_if.slave  bus
);

  localparam int          AW    = (total_gate > 1) ? $clog2(total_gate) : 1;
  localparam logic [31:0] TOTAL = 32'(total_gate);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state;
  logic [31:0] gate_cnt;
  logic [AW-1:0] rd_ptr;

  logic [1:0]  mem_type [total_gate];
  logic [31:0] mem_pos  [total_gate];
  logic [31:0] mem_pos2 [total_gate];

  logic          run_ok;
  logic          has_next;
  logic [AW-1:0] nxt_ptr;

  assign run_ok   = (bus.num_gate != 32'd0) && (bus.num_gate <= TOTAL);
  assign has_next = (bus.gate_index + 32'd1) < gate_cnt;
  assign nxt_ptr  = rd_ptr + AW'(1);

`ifdef GATE_CHECK_EN
  localparam logic [31:0] NQ = 32'(num_qubit);

  // A gate is flagged when any qubit it touches is out of range, or a CNOT targets its control.
  function automatic logic gate_bad(input logic [1:0] t, input logic [31:0] p, input logic [31:0] p2);
    return (p >= NQ) || ((t == 2'd2) && ((p2 >= NQ) || (p2 == p)));
  endfunction
`endif

  // NOTE: the program store has no reset; the host always writes it before a run,
  // and leaving it out keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.prog_we && bus.prog_addr < TOTAL) begin
      mem_type[bus.prog_addr[AW-1:0]] <= bus.prog_gate_type;
      mem_pos [bus.prog_addr[AW-1:0]] <= bus.prog_qubit_pos;
      mem_pos2[bus.prog_addr[AW-1:0]] <= bus.prog_qubit_pos2;
    end
  end

  // NOTE: non-blocking updates mean a run coincident with a write to entry 0
  // loads the entry as it was before that write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      gate_cnt       <= '0;
      rd_ptr         <= '0;
      bus.start      <= 1'b0;
      bus.done       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.cfg_err    <= 1'b0;
      bus.gate_type  <= '0;
      bus.qubit_pos  <= '0;
      bus.qubit_pos2 <= '0;
      bus.gate_index <= '0;
`ifdef GATE_CHECK_EN
      bus.gate_err   <= 1'b0;
`endif
    end else begin
      bus.start <= 1'b0;
      bus.done  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.run) begin
            if (run_ok) begin
              gate_cnt       <= bus.num_gate;
              rd_ptr         <= '0;
              bus.gate_type  <= mem_type[0];
              bus.qubit_pos  <= mem_pos[0];
              bus.qubit_pos2 <= mem_pos2[0];
              bus.gate_index <= '0;
              bus.start      <= 1'b1;
              bus.busy       <= 1'b1;
              bus.cfg_err    <= 1'b0;
`ifdef GATE_CHECK_EN
              bus.gate_err   <= gate_bad(mem_type[0], mem_pos[0], mem_pos2[0]);
`endif
              state          <= RUN;
            end else begin
              bus.cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.update_gate_info) begin
            if (has_next) begin
              rd_ptr         <= nxt_ptr;
              bus.gate_type  <= mem_type[nxt_ptr];
              bus.qubit_pos  <= mem_pos[nxt_ptr];
              bus.qubit_pos2 <= mem_pos2[nxt_ptr];
              bus.gate_index <= bus.gate_index + 32'd1;
`ifdef GATE_CHECK_EN
              bus.gate_err   <= bus.gate_err |
                                gate_bad(mem_type[nxt_ptr], mem_pos[nxt_ptr], mem_pos2[nxt_ptr]);
`endif
            end else begin
              // last gate consumed: hold it on the outputs while the readout finishes
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (bus.done_readout) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sequencer.sv
// Scoreboard bench for gate_sequencer: a phase-level reference model queues expected
// start/gate/done events and an independent monitor pops them as the DUT presents them.
module tb_gate_sequencer;
  localparam int NQ = 3;
  localparam int TG = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gate_sequencer_if bus ();
  gate_sequencer #(.num_qubit(NQ), .total_gate(TG)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef enum int {EV_START, EV_GATE, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [1:0]  t;
    logic [31:0] p;
    logic [31:0] p2;
    logic [31:0] idx;
  } ev_t;
  typedef enum int {P_IDLE, P_RUN, P_DRAIN, P_DONE} phase_t;

  int n_vec = 0;
  int n_err = 0;
  ev_t exp_q[$];

  // reference model state
  logic [1:0]  m_type [TG];
  logic [31:0] m_pos  [TG];
  logic [31:0] m_pos2 [TG];
  phase_t      m_ph   = P_IDLE;
  int          m_n    = 0;
  ev_t         m_cur  = '{EV_GATE, 2'd0, 32'd0, 32'd0, 32'd0};
  bit          m_cfg  = 1'b0;
  bit          m_gerr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit bad(input ev_t e);
    return (e.p >= NQ) || (e.t == 2'd2 && (e.p2 >= NQ || e.p2 == e.p));
  endfunction

  function automatic ev_t entry(input ev_kind_t k, input int i);
    ev_t e;
    e.kind = k; e.t = m_type[i]; e.p = m_pos[i]; e.p2 = m_pos2[i]; e.idx = 32'(i);
    return e;
  endfunction

  // ---------------- monitor ----------------
  logic [31:0] prev_idx = '0;
  ev_t         mon_e;
  ev_kind_t    mon_k;
  always @(negedge clk) begin
    if (!rst) begin
      prev_idx = '0;
    end else begin
      if (bus.start || bus.done || bus.gate_index != prev_idx) begin
        mon_k = bus.done ? EV_DONE : (bus.start ? EV_START : EV_GATE);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event: got kind %0d idx %0d, expected no event (t=%0t)",
                   mon_k, bus.gate_index, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("ev_kind",    64'(mon_k),        64'(mon_e.kind));
          check("gate_type",  64'(bus.gate_type), 64'(mon_e.t));
          check("qubit_pos",  64'(bus.qubit_pos), 64'(mon_e.p));
          check("qubit_pos2", 64'(bus.qubit_pos2), 64'(mon_e.p2));
          check("gate_index", 64'(bus.gate_index), 64'(mon_e.idx));
        end
      end
      prev_idx = bus.gate_index;
    end
  end

  // ---------------- stimulus + model ----------------
  task automatic cycle_in(input bit we, input logic [31:0] addr, input logic [1:0] t,
                          input logic [31:0] p, input logic [31:0] p2, input bit run,
                          input logic [31:0] n, input bit upd, input bit dro);
    phase_t ph = m_ph;
    bus.prog_we = we; bus.prog_addr = addr; bus.prog_gate_type = t;
    bus.prog_qubit_pos = p; bus.prog_qubit_pos2 = p2;
    bus.run = run; bus.num_gate = n; bus.update_gate_info = upd; bus.done_readout = dro;
    if (ph == P_IDLE && run) begin
      if (n >= 1 && n <= TG) begin
        m_n = int'(n); m_cur = entry(EV_START, 0); exp_q.push_back(m_cur);
        m_ph = P_RUN; m_cfg = 1'b0; m_gerr = bad(m_cur);
      end else begin
        m_cfg = 1'b1;
      end
    end
    if (ph == P_RUN && upd) begin
      if (int'(m_cur.idx) + 1 < m_n) begin
        m_cur = entry(EV_GATE, int'(m_cur.idx) + 1); exp_q.push_back(m_cur);
        m_gerr = m_gerr | bad(m_cur);
      end else begin
        m_ph = P_DRAIN;
      end
    end
    if (ph == P_DRAIN && dro) begin
      m_cur.kind = EV_DONE; exp_q.push_back(m_cur); m_ph = P_DONE;
    end
    if (ph == P_DONE) m_ph = P_IDLE;
    if (ph == P_IDLE && we && addr < TG) begin
      m_type[addr] = t; m_pos[addr] = p; m_pos2[addr] = p2;
    end
    @(posedge clk);
    @(negedge clk);
    check("busy",    64'(bus.busy),    64'(m_ph == P_RUN || m_ph == P_DRAIN));
    check("cfg_err", 64'(bus.cfg_err), 64'(m_cfg));
`ifdef GATE_CHECK_EN
    check("gate_err", 64'(bus.gate_err), 64'(m_gerr));
`endif
    bus.prog_we = 1'b0; bus.run = 1'b0; bus.update_gate_info = 1'b0; bus.done_readout = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_run(input logic [31:0] n); cycle_in(0, 0, 0, 0, 0, 1, n, 0, 0); endtask
  task automatic do_upd(); cycle_in(0, 0, 0, 0, 0, 0, 0, 1, 0); endtask
  task automatic do_dro(); cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic do_we(input logic [31:0] a, input logic [1:0] t, input logic [31:0] p,
                       input logic [31:0] p2);
    cycle_in(1, a, t, p, p2, 0, 0, 0, 0);
  endtask

  task automatic check_held(input string tag);
    check({tag, "_type"}, 64'(bus.gate_type),  64'(m_cur.t));
    check({tag, "_pos"},  64'(bus.qubit_pos),  64'(m_cur.p));
    check({tag, "_pos2"}, 64'(bus.qubit_pos2), 64'(m_cur.p2));
    check({tag, "_idx"},  64'(bus.gate_index), 64'(m_cur.idx));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.prog_we = 0; bus.prog_addr = 0; bus.prog_gate_type = 0; bus.prog_qubit_pos = 0;
    bus.prog_qubit_pos2 = 0; bus.num_gate = 0; bus.run = 0; bus.update_gate_info = 0;
    bus.done_readout = 0;
    repeat (2) @(negedge clk);
    // reset state
    check("rst_start", 64'(bus.start), 0);
    check("rst_busy",  64'(bus.busy),  0);
    check("rst_done",  64'(bus.done),  0);
    check("rst_cfg",   64'(bus.cfg_err), 0);
    check_held("rst");
    #2 rst = 1'b1;
    @(negedge clk);

    // fill the whole program so no entry is left unknown
    for (int i = 0; i < TG; i++)
      do_we(i, 2'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 2));

    // directed three-gate program with spaced updates
    do_we(0, 2'd0, 0, 0);
    do_we(1, 2'd2, 0, 1);
    do_we(2, 2'd1, 2, 0);
    do_run(3);
    check("d1_start", 64'(bus.start), 1);
    idle(2); do_upd; idle(1); do_upd; idle(3); do_upd;
    check("d1_drain_busy", 64'(bus.busy), 1);
    idle(2);
    do_dro;
    check("d1_done", 64'(bus.done), 1);
    idle(1);
    check("d1_done_pulse", 64'(bus.done), 0);

    // illegal run counts
    do_run(0);
    check("cfg_zero", 64'(bus.cfg_err), 1);
    do_run(31);
    check("cfg_over", 64'(bus.cfg_err), 1);
    do_run(3);
    check("cfg_clear", 64'(bus.cfg_err), 0);
    do_upd; do_upd; do_upd; do_dro; idle(1);

    // back-to-back updates from the start cycle onward
    do_run(4);
    for (int k = 1; k <= 3; k++) begin
      do_upd;
      check("b2b_idx", 64'(bus.gate_index), 64'(k));
    end
    do_upd; do_dro; idle(1);

    // writes and runs during RUN are ignored; update in IDLE changes nothing
    do_run(3);
    do_we(0, 2'd3, 7, 7);
    do_we(1, 2'd3, 7, 7);
    do_run(2);
    do_upd; do_upd; do_upd; do_dro; idle(1);
    do_upd;
    check_held("idle_upd");
    do_run(3);
    do_upd; do_upd; do_upd; do_dro; idle(1);

    // run and write in the same cycle: run sees the old entry 0
    cycle_in(1, 0, 2'd3, 1, 1, 1, 1, 0, 0);
    do_upd; do_dro; idle(1);
    do_run(1); do_upd; do_dro; idle(1);

    // reset mid-run, then replay
    do_run(5); do_upd; do_upd;
    check("pre_rst_idx", 64'(bus.gate_index), 2);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_start", 64'(bus.start), 0);
    check("mid_rst_busy",  64'(bus.busy),  0);
    check("mid_rst_done",  64'(bus.done),  0);
    check("mid_rst_type",  64'(bus.gate_type), 0);
    check("mid_rst_pos",   64'(bus.qubit_pos), 0);
    check("mid_rst_pos2",  64'(bus.qubit_pos2), 0);
    check("mid_rst_idx",   64'(bus.gate_index), 0);
    check("mid_rst_queue", 64'(exp_q.size()), 0);
    m_ph = P_IDLE; m_cfg = 1'b0; m_gerr = 1'b0; m_cur = '{EV_GATE, 2'd0, 32'd0, 32'd0, 32'd0};
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    do_run(5);
    for (int k = 0; k < 5; k++) do_upd;
    do_dro; idle(1);

`ifdef GATE_CHECK_EN
    do_we(0, 2'd2, 1, 1);
    do_run(1);
    check("gerr_set", 64'(bus.gate_err), 1);
    do_upd; do_dro; idle(2);
    check("gerr_sticky", 64'(bus.gate_err), 1);
    do_we(0, 2'd0, 0, 0);
    do_run(1);
    check("gerr_clear", 64'(bus.gate_err), 0);
    do_upd; do_dro; idle(1);
`endif

    // randomized traffic across all phases
    for (int c = 0; c < 2500; c++) begin
      logic [31:0] n;
      n = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom_range(1, 6));
      cycle_in($urandom_range(0, 4) == 0, $urandom_range(0, 33), 2'($urandom_range(0, 3)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9) == 0, n,
               $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end
    for (int c = 0; c < 80 && m_ph != P_IDLE; c++) cycle_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3);
    check("scoreboard_empty", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
